// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM duty decoder.
package pwm_dec_pkg;

    typedef enum logic {SEEK = 1'b0, MEASURE = 1'b1} state_t;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [DUTY_W-1:0] DUTY_ZERO = 8'h00;
    localparam int COUNT_W_DEFAULT = 12;

endpackage

// File: rtl/pwm_dec_divider.sv
// Restoring divider producing floor(h*256/p): one load cycle, then 8 iteration cycles.
// busy covers the done cycle, so a new start cannot clobber a result being consumed.
module pwm_dec_divider
    import pwm_dec_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               abort,
    input  logic               start,
    input  logic [COUNT_W-1:0] h,
    input  logic [COUNT_W-1:0] p,
    output logic               busy,
    output logic               done,
    output logic [DUTY_W-1:0]  q
);

    logic               running;
    logic               sat;
    logic [COUNT_W:0]   rem;
    logic [COUNT_W:0]   rem_sh;
    logic [COUNT_W-1:0] divisor;
    logic [DUTY_W-1:0]  quo;
    logic [2:0]         bit_cnt;

    assign rem_sh = {rem[COUNT_W-1:0], 1'b0};
    assign busy   = running | done;
    assign q      = sat ? DUTY_FULL : quo;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            running <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            rem     <= '0;
            divisor <= '0;
            quo     <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                running <= 1'b1;
                sat     <= (h >= p) || (p == '0);
                rem     <= {1'b0, h};
                divisor <= p;
                quo     <= '0;
                bit_cnt <= '0;
            end else if (running) begin
                // Remainder stays below the divisor, so the doubled value fits in COUNT_W+1 bits.
                if (rem_sh >= {1'b0, divisor}) begin
                    rem <= rem_sh - {1'b0, divisor};
                    quo <= {quo[DUTY_W-2:0], 1'b1};
                end else begin
                    rem <= rem_sh;
                    quo <= {quo[DUTY_W-2:0], 1'b0};
                end
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures an incoming PWM waveform and recovers its 8-bit duty code (0x00 low .. 0xFF high).
// Define PWM_DEC_GLITCH_FILTER_EN to add a 2-of-3 majority filter after the synchronizer.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int COUNT_W     = COUNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               pwm_in,
    input  logic               clr_overrun,
    output logic [DUTY_W-1:0]  duty_out,
    output logic [COUNT_W-1:0] period_out,
    output logic [COUNT_W-1:0] high_out,
    output logic               valid,
    output logic               stuck,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   raw_level;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;

    state_t             state;
    logic [COUNT_W-1:0] period_cnt;
    logic [COUNT_W-1:0] high_cnt;
    logic [COUNT_W-1:0] seek_cnt;
    logic [COUNT_W-1:0] p_lat;
    logic [COUNT_W-1:0] h_lat;
    logic               stuck_pending;
    logic               stuck_level;

    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [DUTY_W-1:0]  div_q;
    logic               stuck_hit;

    assign raw_level = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;
    logic       maj;

    assign maj = (raw_level & hist[0]) | (raw_level & hist[1]) | (hist[0] & hist[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], raw_level};
            filt <= maj;
        end
    end

    assign s_sync = filt;
`else
    assign s_sync = raw_level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev <= s_sync;
        end
    end

    always_comb begin
        rise      = s_sync & ~s_prev;
        div_start = en && (state == MEASURE) && rise && !div_busy;
        stuck_hit = 1'b0;
        if (en && !rise) begin
            if (state == SEEK) stuck_hit = (seek_cnt == CNT_MAX);
            else               stuck_hit = (period_cnt == CNT_MAX);
        end
    end

    pwm_dec_divider #(.COUNT_W(COUNT_W)) u_divider (
        .clk   (clk),
        .rst   (rst),
        .abort (~en),
        .start (div_start),
        .h     (high_cnt),
        .p     (period_cnt),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SEEK;
            period_cnt    <= '0;
            high_cnt      <= '0;
            seek_cnt      <= '0;
            p_lat         <= '0;
            h_lat         <= '0;
            stuck_pending <= 1'b0;
            stuck_level   <= 1'b0;
            duty_out      <= DUTY_ZERO;
            period_out    <= '0;
            high_out      <= '0;
            valid         <= 1'b0;
            stuck         <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            valid <= 1'b0;

            // A new overrun outranks a coincident clear.
            if (en && (state == MEASURE) && rise && div_busy) overrun <= 1'b1;
            else if (clr_overrun)                             overrun <= 1'b0;

            if (!en) begin
                state         <= SEEK;
                period_cnt    <= '0;
                high_cnt      <= '0;
                seek_cnt      <= '0;
                stuck_pending <= 1'b0;
            end else begin
                if (div_done) begin
                    valid      <= 1'b1;
                    stuck      <= 1'b0;
                    duty_out   <= div_q;
                    period_out <= p_lat;
                    high_out   <= h_lat;
                end else if (stuck_hit && !div_busy) begin
                    valid      <= 1'b1;
                    stuck      <= 1'b1;
                    duty_out   <= s_sync ? DUTY_FULL : DUTY_ZERO;
                    period_out <= '0;
                    high_out   <= '0;
                end else if (stuck_pending && !div_busy) begin
                    valid      <= 1'b1;
                    stuck      <= 1'b1;
                    duty_out   <= stuck_level ? DUTY_FULL : DUTY_ZERO;
                    period_out <= '0;
                    high_out   <= '0;
                end

                // A timeout seen while the divider runs is parked until its result is out.
                if (stuck_hit && div_busy) begin
                    stuck_pending <= 1'b1;
                    stuck_level   <= s_sync;
                end else if (!div_busy) begin
                    stuck_pending <= 1'b0;
                end

                if (div_start) begin
                    p_lat <= period_cnt;
                    h_lat <= high_cnt;
                end

                case (state)
                    SEEK: begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                        if (rise) begin
                            state      <= MEASURE;
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                            seek_cnt   <= '0;
                        end else if (stuck_hit) begin
                            seek_cnt <= '0;
                        end else begin
                            seek_cnt <= seek_cnt + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                        end else if (stuck_hit) begin
                            state      <= SEEK;
                            period_cnt <= '0;
                            high_cnt   <= '0;
                            seek_cnt   <= '0;
                        end else begin
                            period_cnt <= period_cnt + CNT_ONE;
                            if (s_sync) high_cnt <= high_cnt + CNT_ONE;
                        end
                    end
                    default: state <= SEEK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: table vectors, random vectors and multi-cycle corner sequences.
module tb_pwm_duty_decoder;

    localparam int CW = 12;
    localparam int RW = 8 + CW + CW + 1;

    typedef struct {
        int         period;
        int         high;
        logic [7:0] duty;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pwm_in;
    logic          clr_overrun;
    logic [7:0]    duty_out;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          valid;
    logic          stuck;
    logic          overrun;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_got;
    logic [RW-1:0] mon_exp;
    int            checks = 0;
    int            errors = 0;
    logic          sb_ignore = 1'b0;
    logic          seen;
    vec_t          vecs[9];

    pwm_duty_decoder #(.COUNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pwm_in      (pwm_in),
        .clr_overrun (clr_overrun),
        .duty_out    (duty_out),
        .period_out  (period_out),
        .high_out    (high_out),
        .valid       (valid),
        .stuck       (stuck),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && valid && !sb_ignore) begin
            mon_got = {duty_out, period_out, high_out, stuck};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got duty=%h period=%0d high=%0d stuck=%b required no valid",
                         duty_out, period_out, high_out, stuck);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result got duty=%h period=%0d high=%0d stuck=%b required duty=%h period=%0d high=%0d stuck=%b",
                             duty_out, period_out, high_out, stuck,
                             mon_exp[RW-1 -: 8], mon_exp[2*CW:CW+1], mon_exp[CW:1], mon_exp[0]);
                end
            end
        end
    end

    function automatic logic [RW-1:0] pack(input logic [7:0] d, input int p, input int h, input logic s);
        logic [CW-1:0] pp;
        logic [CW-1:0] hh;
        pp = p[CW-1:0];
        hh = h[CW-1:0];
        return {d, pp, hh, s};
    endfunction

    function automatic logic [7:0] model_duty(input int p, input int h);
        int tmp;
        if (p == 0 || h >= p) return 8'hFF;
        tmp = (h * 256) / p;
        return tmp[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        clr_overrun = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic drive_period(input int p, input int h);
        pwm_in = 1'b1;
        tick(h);
        pwm_in = 1'b0;
        tick(p - h);
    endtask

    // Closing rising edge completes the last period; en then drops so no timeout follows.
    task automatic final_edge();
        pwm_in = 1'b1;
        tick(20);
        en = 1'b0;
        tick(2);
        pwm_in = 1'b0;
        tick(3);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int p;
        int h;

        vecs[0] = '{256, 128, 8'h80};
        vecs[1] = '{256, 64, 8'h40};
        vecs[2] = '{256, 192, 8'hC0};
        vecs[3] = '{100, 33, 8'h54};
        vecs[4] = '{10, 9, 8'hE6};
        vecs[5] = '{10, 1, 8'h19};
        vecs[6] = '{300, 299, 8'hFF};
        vecs[7] = '{1000, 1, 8'h00};
        vecs[8] = '{2000, 1999, 8'hFF};

        // Reset state
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        clr_overrun = 1'b0;
        tick(3);
        check("reset_duty", 32'(duty_out), 32'h0);
        check("reset_period", 32'(period_out), 32'h0);
        check("reset_high", 32'(high_out), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_stuck", 32'(stuck), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);

        // Table vectors: three full periods each, first rise only arms the measurement
        for (int v = 0; v < 9; v++) begin
            do_reset();
            en = 1'b1;
            tick(5);
            for (int m = 0; m < 3; m++) exp_q.push_back(pack(vecs[v].duty, vecs[v].period, vecs[v].high, 1'b0));
            for (int m = 0; m < 3; m++) drive_period(vecs[v].period, vecs[v].high);
            final_edge();
            drain("table");
        end

        // Random vectors against the floor(H*256/P) model
        for (int r = 0; r < 4; r++) begin
            p = int'($urandom_range(600, 10));
            h = int'($urandom_range(p - 1, 1));
            do_reset();
            en = 1'b1;
            tick(5);
            for (int m = 0; m < 2; m++) exp_q.push_back(pack(model_duty(p, h), p, h, 1'b0));
            for (int m = 0; m < 2; m++) drive_period(p, h);
            final_edge();
            drain("random");
        end

        // Duty switch mid-stream
        do_reset();
        en = 1'b1;
        tick(5);
        for (int m = 0; m < 3; m++) exp_q.push_back(pack(8'h40, 256, 64, 1'b0));
        for (int m = 0; m < 3; m++) exp_q.push_back(pack(8'hC0, 256, 192, 1'b0));
        for (int m = 0; m < 3; m++) drive_period(256, 64);
        for (int m = 0; m < 3; m++) drive_period(256, 192);
        final_edge();
        drain("switch");
        tick(10);
        check("hold_en_low_duty", 32'(duty_out), 32'hC0);
        check("hold_en_low_period", 32'(period_out), 32'd256);

        // Reset four cycles after a period latch: divider killed, outputs cleared
        en = 1'b1;
        tick(5);
        drive_period(256, 128);
        pwm_in = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(1);
        check("rst_mid_duty", 32'(duty_out), 32'h0);
        check("rst_mid_period", 32'(period_out), 32'h0);
        check("rst_mid_high", 32'(high_out), 32'h0);
        check("rst_mid_valid", 32'(valid), 32'h0);
        pwm_in = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(30);
        drain("rst_quiet");
        for (int m = 0; m < 2; m++) exp_q.push_back(pack(8'h80, 256, 128, 1'b0));
        for (int m = 0; m < 2; m++) drive_period(256, 128);
        final_edge();
        drain("rst_restart");

        // Stuck high, then stuck low
        do_reset();
        en = 1'b1;
        exp_q.push_back(pack(8'hFF, 0, 0, 1'b1));
        pwm_in = 1'b1;
        tick(5000);
        drain("stuck_high");
        do_reset();
        en = 1'b1;
        exp_q.push_back(pack(8'h00, 0, 0, 1'b1));
        pwm_in = 1'b0;
        tick(5000);
        drain("stuck_low");

        // Overrun from a too-short period, sticky clear, and set winning over clear
        do_reset();
        en = 1'b1;
        sb_ignore = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pwm_in = ((c % 6) < 3);
            tick(1);
            if (overrun) seen = 1'b1;
        end
        check("overrun_set", 32'(seen), 32'h1);
        pwm_in = 1'b0;
        tick(20);
        check("overrun_sticky", 32'(overrun), 32'h1);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("overrun_clear", 32'(overrun), 32'h0);
        clr_overrun = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            pwm_in = ((c % 6) < 3);
            tick(1);
            if (overrun) seen = 1'b1;
        end
        clr_overrun = 1'b0;
        pwm_in = 1'b0;
        tick(20);
        check("overrun_set_wins", 32'(seen), 32'h1);
        en = 1'b0;
        tick(2);
        sb_ignore = 1'b0;

        // One-cycle glitch in the low phase
        do_reset();
        en = 1'b1;
        tick(5);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        for (int m = 0; m < 3; m++) exp_q.push_back(pack(8'h80, 256, 128, 1'b0));
`else
        exp_q.push_back(pack(8'h80, 256, 128, 1'b0));
        exp_q.push_back(pack(8'hA3, 200, 128, 1'b0));
        exp_q.push_back(pack(8'h04, 56, 1, 1'b0));
        exp_q.push_back(pack(8'h80, 256, 128, 1'b0));
`endif
        drive_period(256, 128);
        pwm_in = 1'b1;
        tick(128);
        pwm_in = 1'b0;
        tick(72);
        pwm_in = 1'b1;
        tick(1);
        pwm_in = 1'b0;
        tick(55);
        drive_period(256, 128);
        final_edge();
        drain("glitch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive side of the PWM peripheral: measures an incoming PWM waveform and recovers its 8-bit duty code.
- Uses the same 0x00 = always low, 0xFF = always high convention as the PWM generator.
- Sits beside the PWM peripheral in the tile top level. Used for loopback self-test (generator out → decoder in) and for reading external PWM sources.
- Reports period, high time and duty with a valid pulse per measured period.

Parameters:
- COUNT_W, 12: width of period/high-time counters; the stuck-level timeout is 2^COUNT_W-1 cycles.
- SYNC_STAGES, 2: number of synchronizer flops on pwm_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  measurement enable. While low: FSM held in SEEK, counters cleared, outputs hold their last values.
- pwm_in  input  1  asynchronous PWM input.
- clr_overrun  input  1  single-cycle pulse; clears the sticky overrun flag.
- duty_out  output  8  recovered duty code.
- period_out  output  COUNT_W  last measured period in clk cycles; 0 when stuck.
- high_out  output  COUNT_W  last measured high time in clk cycles.
- valid  output  1  one-cycle pulse when duty_out, period_out, high_out and stuck update.
- stuck  output  1  high when the last result came from a timeout (constant level).
- overrun  output  1  sticky flag: a period completed while the divider was busy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset, every output and all internal state go to 0, and the FSM enters SEEK.
- Input conditioning: SYNC_STAGES-flop synchronizer, then one extra flop for edge detect. rise = s_sync & ~s_prev. Latency from a pwm_in edge to rise is SYNC_STAGES+1 cycles.
- FSM SEEK: period_cnt and high_cnt are held at 0; waits for rise, then goes to MEASURE. The timeout counter runs here too: after 2^COUNT_W-1 cycles without rise, report a stuck result and stay in SEEK.
- FSM MEASURE, counting:
  - On a rise cycle, period_cnt loads 1 and high_cnt loads 1.
  - Otherwise period_cnt increments, and high_cnt increments when s_sync=1.
- FSM MEASURE, next rise:
  - If the divider is idle: latch the period_cnt/high_cnt values from before reload into P/H and start the divider. Counters reload as above in the same cycle.
  - If the divider is busy: discard the measurement and set overrun. overrun stays set until clr_overrun or rst; if a new overrun and clr_overrun coincide, set wins.
- FSM MEASURE, timeout: when period_cnt reaches 2^COUNT_W-1 with no rise, report a stuck result and return to SEEK.
- Stuck result (next cycle after detection): valid=1, stuck=1, period_out=0, high_out=0, duty_out=0xFF if s_sync=1 else 0x00. Suppressed if the divider is busy; the stuck result is then posted when the divider finishes.
- Divider: computes Q = floor(H*256/P) as a restoring divider.
  - One load cycle, then 8 iteration cycles, one quotient bit per cycle.
  - Results at 9 cycles after latch: valid=1, stuck=0, duty_out=Q, period_out=P, high_out=H.
  - If H≥P or P=0, saturate duty_out to 0xFF.
- Minimum resolvable period is 10 cycles; shorter periods produce overrun on alternate edges.
- en deassert mid-operation: the divider aborts with no valid pulse, the FSM goes to SEEK, and outputs hold.
- rst mid-divide: no valid pulse; all outputs 0.

Optional Feature:
- Macro: PWM_DEC_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer. A level change must persist for 2 of 3 samples, so single-cycle glitches are rejected. Edge latency grows by 2 cycles; period and high counts are unaffected in steady state.
- Undefined: the synchronizer output feeds edge detect directly; a 1-cycle glitch registers as an edge.

Decomposition:
- Package pwm_dec_pkg:
  - state enum {SEEK, MEASURE};
  - DUTY_W=8;
  - DUTY_FULL=8'hFF, DUTY_ZERO=8'h00;
  - default COUNT_W.
- Sub-module pwm_dec_divider: start/busy/done handshake, inputs H and P (COUNT_W), output 8-bit Q with saturation, 9-cycle latency.

Test Plan:
1. COUNT_W=12, pwm_in period 256, high 128, en=1 → after first full period: valid pulses every 256 cycles; duty_out=0x80, period_out=256, high_out=128, stuck=0.
2. Period 256, high 64, then switched to high 192 mid-stream → duty_out 0x40, then 0xC0 starting from the first full period at the new setting.
3. pwm_in held 1 for 5000 cycles → exactly one valid with stuck=1, duty_out=0xFF, period_out=0; same with pwm_in held 0 → duty_out=0x00.
4. Period 6, high 3 → overrun=1 within 20 cycles; clr_overrun pulse clears it; in a same-cycle set and clear, overrun stays 1.
5. rst asserted 4 cycles after a period latch (divider mid-run) → no valid; all outputs 0 the next cycle; the FSM restarts in SEEK and needs a fresh rise.
6. With PWM_DEC_GLITCH_FILTER_EN: period 256, high 128, plus a 1-cycle high glitch in the low phase → duty_out stays 0x80 and no extra valid. Without the macro → a spurious short-period result or overrun.
